// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA datapath blocks.
//   exp_state_e : mod_exp controller states (IDLE..FIN)
//   mm_state_e  : mod_mul sequencer states
//   ONE         : the residue 1; size-cast to the operand width at the use site
//                 because the package itself is width-agnostic.
// ----------------------------------------------------------------------------
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQR,
        SQR_W,
        MUL,
        MUL_W,
        FIN
    } exp_state_e;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_RUN,
        MM_DONE
    } mm_state_e;

    localparam int unsigned ONE = 1;

endpackage

// File: rtl/mod_mul.sv
// ----------------------------------------------------------------------------
// mod_mul
// Sequential modular multiplier z = x * y mod m (interleaved shift-and-add,
// MSB of y first, one bit per cycle, k cycles per product).
// Ports:
//   clk   in  1  clock, posedge
//   rst_n in  1  synchronous, active-low reset
//   start in  1  request; sampled only while idle, operands captured then
//   x, y  in  k  operands, both < m
//   z     out k  product residue; valid while done=1
//   done  out 1  one-cycle pulse when z is ready
// After done the unit spends one cycle idle-bound before it can sample start,
// so a requester that drops start on seeing done never retriggers it.
// ----------------------------------------------------------------------------
module mod_mul
    import rsa_pkg::*;
#(
    parameter int unsigned  k    = 12,
    parameter int unsigned  logk = 4,
    parameter logic [k-1:0] m    = 12'hFFD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [k-1:0] x,
    input  logic [k-1:0] y,
    output logic [k-1:0] z,
    output logic         done
);

    mm_state_e       r_state, w_state_next;
    logic [k-1:0]    r_x, w_x_next;
    logic [k-1:0]    r_y, w_y_next;
    logic [k-1:0]    r_p, w_p_next;
    logic [logk-1:0] r_cnt, w_cnt_next;

    // One extra bit holds 2p and p+x before the conditional subtraction.
    logic [k:0]      w_dbl, w_dbl_red, w_sum, w_sum_red;
    logic [k-1:0]    w_p_step;

    always_comb begin
        w_dbl     = {r_p, 1'b0};
        w_dbl_red = (w_dbl >= {1'b0, m}) ? (w_dbl - {1'b0, m}) : w_dbl;
        w_sum     = w_dbl_red + (r_y[k-1] ? {1'b0, r_x} : {(k+1){1'b0}});
        w_sum_red = (w_sum >= {1'b0, m}) ? (w_sum - {1'b0, m}) : w_sum;
        w_p_step  = w_sum_red[k-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_p_next     = r_p;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            MM_IDLE: begin
                if (start) begin
                    w_x_next     = x;
                    w_y_next     = y;
                    w_p_next     = '0;
                    w_cnt_next   = logk'(k - 1);
                    w_state_next = MM_RUN;
                end
            end
            MM_RUN: begin
                w_p_next = w_p_step;
                w_y_next = {r_y[k-2:0], 1'b0};
                if (r_cnt == '0) begin
                    w_state_next = MM_DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            MM_DONE: begin
                w_state_next = MM_IDLE;
            end
            default: begin
                w_state_next = MM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MM_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_p     <= w_p_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign z    = r_p;
    assign done = (r_state == MM_DONE);

endmodule

// File: rtl/mod_exp.sv
// ----------------------------------------------------------------------------
// mod_exp
// Modular exponentiation z = x^e mod m, left-to-right binary square-and-
// multiply. Every square/multiply goes through the single mod_mul instance.
// Ports:
//   clk   in  1  clock, posedge
//   rst   in  1  synchronous, active-high reset (aborts any operation)
//   start in  1  request; sampled only in IDLE
//   x     in  k  base (< m), captured when start is accepted
//   e     in  k  exponent, captured when start is accepted
//   z     out k  result; valid with done, held until the next result
//   busy  out 1  high from the cycle after start is accepted until done
//   done  out 1  one-cycle pulse, z ready
// ----------------------------------------------------------------------------
module mod_exp
    import rsa_pkg::*;
#(
    parameter int unsigned  k    = 12,
    parameter int unsigned  logk = 4,
    parameter logic [k-1:0] m    = 12'hFFD
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [k-1:0] x,
    input  logic [k-1:0] e,
    output logic [k-1:0] z,
    output logic         busy,
    output logic         done
);

    exp_state_e      r_state, w_state_next;
    logic [k-1:0]    r_base, w_base_next;
    logic [k-1:0]    r_exp, w_exp_next;
    logic [k-1:0]    r_acc, w_acc_next;
    logic [logk-1:0] r_idx, w_idx_next;
    logic [k-1:0]    r_z, w_z_next;
    logic            r_busy, w_busy_next;
    logic            r_done, w_done_next;
    logic            r_mm_start, w_mm_start_next;
    logic [k-1:0]    r_mm_x, w_mm_x_next;
    logic [k-1:0]    r_mm_y, w_mm_y_next;

    logic [k-1:0]    w_mm_z;
    logic            w_mm_done;
    logic [k-1:0]    w_exp_sh;
    logic            w_ebit;
    logic            w_idx_zero;

    // Shift instead of a variable bit-select so the index width never has to
    // match clog2(k) exactly.
    assign w_exp_sh   = r_exp >> r_idx;
    assign w_ebit     = w_exp_sh[0];
    assign w_idx_zero = (r_idx == '0);

    mod_mul #(
        .k    (k),
        .logk (logk),
        .m    (m)
    ) u_mod_mul (
        .clk   (clk),
        .rst_n (~rst),
        .start (r_mm_start),
        .x     (r_mm_x),
        .y     (r_mm_y),
        .z     (w_mm_z),
        .done  (w_mm_done)
    );

    always_comb begin
        w_state_next    = r_state;
        w_base_next     = r_base;
        w_exp_next      = r_exp;
        w_acc_next      = r_acc;
        w_idx_next      = r_idx;
        w_z_next        = r_z;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_mm_start_next = r_mm_start;
        w_mm_x_next     = r_mm_x;
        w_mm_y_next     = r_mm_y;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_base_next  = x;
                    w_exp_next   = e;
                    w_idx_next   = logk'(k - 1);
                    w_busy_next  = 1'b1;
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                // The leading one loads acc directly: no multiply by 1.
                if (w_ebit) begin
                    w_acc_next = r_base;
                    if (w_idx_zero) begin
                        w_state_next = FIN;
                    end else begin
                        w_idx_next   = r_idx - 1'b1;
                        w_state_next = SQR;
                    end
                end else if (w_idx_zero) begin
                    w_acc_next   = k'(ONE);
                    w_state_next = FIN;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            SQR: begin
                w_mm_x_next     = r_acc;
                w_mm_y_next     = r_acc;
                w_mm_start_next = 1'b1;
                w_state_next    = SQR_W;
            end
            SQR_W: begin
                if (w_mm_done) begin
                    w_acc_next      = w_mm_z;
                    w_mm_start_next = 1'b0;
                    if (w_ebit) begin
                        w_state_next = MUL;
                    end else if (w_idx_zero) begin
                        w_state_next = FIN;
                    end else begin
                        w_idx_next   = r_idx - 1'b1;
                        w_state_next = SQR;
                    end
                end
            end
            MUL: begin
                w_mm_x_next     = r_acc;
                w_mm_y_next     = r_base;
                w_mm_start_next = 1'b1;
                w_state_next    = MUL_W;
            end
            MUL_W: begin
                if (w_mm_done) begin
                    w_acc_next      = w_mm_z;
                    w_mm_start_next = 1'b0;
                    if (w_idx_zero) begin
                        w_state_next = FIN;
                    end else begin
                        w_idx_next   = r_idx - 1'b1;
                        w_state_next = SQR;
                    end
                end
            end
            FIN: begin
                w_z_next     = r_acc;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_exp      <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_z        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mm_start <= 1'b0;
            r_mm_x     <= '0;
            r_mm_y     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_base     <= w_base_next;
            r_exp      <= w_exp_next;
            r_acc      <= w_acc_next;
            r_idx      <= w_idx_next;
            r_z        <= w_z_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_mm_start <= w_mm_start_next;
            r_mm_x     <= w_mm_x_next;
            r_mm_y     <= w_mm_y_next;
        end
    end

    assign z    = r_z;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mod_exp.sv
// ----------------------------------------------------------------------------
// tb_mod_exp
// Self-checking bench for mod_exp (k=8, logk=4, m=251). Expected results come
// from a plain-arithmetic power model; square/multiply counts from the binary
// form of e.
// ----------------------------------------------------------------------------
module tb_mod_exp;
    import rsa_pkg::*;

    localparam int unsigned K  = 8;
    localparam logic [7:0]  MV = 8'hFB;
    localparam int          MI = 251;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] e;
    logic [7:0] z;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mod_exp #(
        .k    (K),
        .logk (4),
        .m    (MV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .e     (e),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;
    int   sq_cnt   = 0;
    int   mul_cnt  = 0;
    int   exp_z    = 0;
    int   last_z   = 0;
    logic prev_done = 1'b0;
    logic prev_mm   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int model_pow(input int b, input int ex);
        int r = 1;
        for (int i = 0; i < ex; i++) r = (r * b) % MI;
        return r;
    endfunction

    function automatic int msb_of(input int ex);
        int r = 0;
        for (int i = 0; i < 8; i++) if ((ex >> i) & 1) r = i;
        return r;
    endfunction

    function automatic int popcnt(input int ex);
        int r = 0;
        for (int i = 0; i < 8; i++) r += (ex >> i) & 1;
        return r;
    endfunction

    // Compare process: result at every done, hold between operations, and
    // mod_mul launches classified as square or multiply.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
            prev_mm   = 1'b0;
        end else begin
            if (done) begin
                check("z_at_done", z, exp_z);
                check("busy_at_done", busy, 0);
                check("done_width", prev_done, 0);
                done_cnt++;
                last_z = exp_z;
            end else if (!busy) begin
                check("z_held", z, last_z);
            end
            if (dut.r_mm_start && !prev_mm) begin
                if (dut.r_state == SQR_W) sq_cnt++;
                else mul_cnt++;
            end
            prev_mm   = dut.r_mm_start;
            prev_done = done;
        end
    end

    task automatic launch(input logic [7:0] bx, input logic [7:0] be);
        @(negedge clk);
        start = 1'b1;
        x     = bx;
        e     = be;
        exp_z = model_pow(bx, be);
        @(negedge clk);
        start = 1'b0;
        x     = 8'($urandom);
        e     = 8'($urandom);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1);
    endtask

    task automatic run(input logic [7:0] bx, input logic [7:0] be, input int lit);
        int d0;
        int exp_sq;
        int exp_mul;
        d0      = done_cnt;
        sq_cnt  = 0;
        mul_cnt = 0;
        exp_sq  = (be == 0) ? 0 : msb_of(be);
        exp_mul = (be == 0) ? 0 : popcnt(be) - 1;
        launch(bx, be);
        wait_done();
        @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("squares", sq_cnt, exp_sq);
        check("multiplies", mul_cnt, exp_mul);
        if (lit >= 0) check("literal_z", z, lit);
    endtask

    initial begin
        int d0;
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        e     = '0;
        repeat (3) @(negedge clk);
        check("reset_z", z, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        // Pin the model itself against hand-computed residues.
        check("model_2_10", model_pow(2, 10), 8'h14);
        check("model_3_250", model_pow(3, 250), 8'h01);
        check("model_2_8", model_pow(2, 8), 8'h05);
        check("model_f7_1", model_pow(8'hF7, 1), 8'hF7);

        run(8'h02, 8'h0A, 8'h14);
        run(8'h03, 8'hFA, 8'h01);
        run(8'h05, 8'h00, 8'h01);
        run(8'hF7, 8'h01, 8'hF7);
        run(8'h00, 8'h05, 8'h00);
        run(8'h02, 8'h08, 8'h05);

        // Start while busy must be ignored.
        d0      = done_cnt;
        sq_cnt  = 0;
        mul_cnt = 0;
        launch(8'h02, 8'h0A);
        repeat (3) @(negedge clk);
        start = 1'b1;
        x     = 8'h03;
        e     = 8'hFA;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        check("busy_start_pulses", done_cnt - d0, 1);
        check("busy_start_sq", sq_cnt, 3);
        check("busy_start_mul", mul_cnt, 1);
        check("busy_start_z", z, 8'h14);
        repeat (5) @(negedge clk);
        check("busy_start_not_latched", busy, 0);

        // Reset in the middle of a square wait.
        launch(8'h02, 8'h0A);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut.r_state == SQR_W) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_sqr_w", found, 1);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        last_z = 0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_z", z, 0);
        run(8'h02, 8'h0A, 8'h14);

        for (int n = 0; n < 40; n++) begin
            run(8'($urandom_range(0, 250)), 8'($urandom_range(0, 255)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
